avalon_ddr_arbiter_2to1: RTL and testbench

- Shares the single 256-bit Avalon-MM master path into the DDR3A system interconnect between two requesters, e.g. the RSA engine master and a future DMA/checker master.
- Round-robin arbitration on commands; commands pass through combinationally once granted.
- Pipelined reads are supported. A pending-owner FIFO routes each readdatavalid beat back to the requester that issued the read.
- Instantiated in the top level between the user masters and the interconnect master conduit.

---
 rtl/avalon_ddr_arbiter_2to1.sv | 188 ++++++++++++++++++
 tb/tb_avalon_ddr_arbiter_2to1.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_ddr_arbiter_2to1.sv
// Two-requester round-robin arbiter onto a single Avalon-MM master path (DDR side).
//
// Commands pass through combinationally from the granted requester. A stalled command
// locks the grant so address/data stay stable until accepted. Each accepted read pushes
// the requester id into an owner FIFO, and every readdatavalid beat pops it to route the
// beat back to the requester that issued the read.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   rN_address_i/read_i/write_i/writedata_i   requester N command inputs
//   rN_waitrequest_o          requester N command stall
//   rN_readdata_o             broadcast of avm_readdata_i
//   rN_readdatavalid_o        read beat belongs to requester N
//   avm_*                     downstream Avalon-MM master signals
//   pend_count_o              reads outstanding
//   err_rdv_o                 sticky: readdatavalid seen with no read pending
module avalon_ddr_arbiter_2to1 #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned MAX_PEND = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic [ADDR_W-1:0]         r0_address_i,
    input  logic                      r0_read_i,
    input  logic                      r0_write_i,
    input  logic [DATA_W-1:0]         r0_writedata_i,
    output logic                      r0_waitrequest_o,
    output logic [DATA_W-1:0]         r0_readdata_o,
    output logic                      r0_readdatavalid_o,

    input  logic [ADDR_W-1:0]         r1_address_i,
    input  logic                      r1_read_i,
    input  logic                      r1_write_i,
    input  logic [DATA_W-1:0]         r1_writedata_i,
    output logic                      r1_waitrequest_o,
    output logic [DATA_W-1:0]         r1_readdata_o,
    output logic                      r1_readdatavalid_o,

    output logic [ADDR_W-1:0]         avm_address_o,
    output logic                      avm_read_o,
    output logic                      avm_write_o,
    output logic [DATA_W-1:0]         avm_writedata_o,
    input  logic                      avm_waitrequest_i,
    input  logic [DATA_W-1:0]         avm_readdata_i,
    input  logic                      avm_readdatavalid_i,

    output logic [$clog2(MAX_PEND):0] pend_count_o,
    output logic                      err_rdv_o
);

    localparam int unsigned PtrW = $clog2(MAX_PEND);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(MAX_PEND);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

    // Arbitration state
    logic lock_q, lock_d;
    logic lock_id_q, lock_id_d;
    logic last_q, last_d;

    // Owner FIFO
    logic [MAX_PEND-1:0] owner_q, owner_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                err_q, err_d;

    logic full, empty;
    logic wr0, wr1, rd0, rd1, req0, req1;
    logic gnt_valid, gnt_id, gnt_wr, gnt_rd;
    logic push, rdv_hit, head_id;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);

    // Write wins when a requester asserts both; a read is no request while the FIFO is full.
    assign wr0  = r0_write_i;
    assign wr1  = r1_write_i;
    assign rd0  = r0_read_i & ~r0_write_i;
    assign rd1  = r1_read_i & ~r1_write_i;
    assign req0 = wr0 | (rd0 & ~full);
    assign req1 = wr1 | (rd1 & ~full);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (lock_q) begin
            gnt_valid = 1'b1;
            gnt_id    = lock_id_q;
        end else if (req0 && req1) begin
            gnt_valid = 1'b1;
            gnt_id    = ~last_q;
        end else if (req0) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b0;
        end else if (req1) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
        end
    end

    assign gnt_wr = gnt_id ? wr1 : wr0;
    assign gnt_rd = gnt_id ? rd1 : rd0;

    // Zero-latency command path. A locked read is dropped from the bus while the FIFO is full.
    assign avm_address_o   = gnt_id ? r1_address_i : r0_address_i;
    assign avm_writedata_o = gnt_id ? r1_writedata_i : r0_writedata_i;
    assign avm_write_o     = rst_ni & gnt_valid & gnt_wr;
    assign avm_read_o      = rst_ni & gnt_valid & gnt_rd & ~full;

    assign r0_waitrequest_o = ~(rst_ni & gnt_valid & ~gnt_id & ~(gnt_rd & full))
                              | avm_waitrequest_i;
    assign r1_waitrequest_o = ~(rst_ni & gnt_valid & gnt_id & ~(gnt_rd & full))
                              | avm_waitrequest_i;

    assign push = avm_read_o & ~avm_waitrequest_i;

    // A beat coinciding with a push into an empty FIFO belongs to the read being pushed.
    assign rdv_hit = avm_readdatavalid_i & (~empty | push);
    assign head_id = empty ? gnt_id : owner_q[rd_ptr_q];

    assign r0_readdata_o      = avm_readdata_i;
    assign r1_readdata_o      = avm_readdata_i;
    assign r0_readdatavalid_o = rst_ni & rdv_hit & ~head_id;
    assign r1_readdatavalid_o = rst_ni & rdv_hit & head_id;

    assign pend_count_o = count_q;
    assign err_rdv_o    = err_q;

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        last_d    = last_q;
        if ((avm_read_o || avm_write_o) && !avm_waitrequest_i) begin
            last_d = gnt_id;
            lock_d = 1'b0;
        end else if (avm_read_o || avm_write_o) begin
            lock_d    = 1'b1;
            lock_id_d = gnt_id;
        end
    end

    always_comb begin
        owner_d  = owner_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            owner_d[wr_ptr_q] = gnt_id;
            wr_ptr_d          = wr_ptr_q + PtrOne;
        end
        if (rdv_hit) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case ({push, rdv_hit})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        err_d = err_q | (avm_readdatavalid_i & ~rdv_hit);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            last_q    <= 1'b1;
            owner_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_avalon_ddr_arbiter_2to1.sv
module tb_avalon_ddr_arbiter_2to1;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 256;
    localparam int unsigned MP = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [AW-1:0] r0_address_i, r1_address_i;
    logic          r0_read_i, r0_write_i, r1_read_i, r1_write_i;
    logic [DW-1:0] r0_writedata_i, r1_writedata_i;
    logic          r0_waitrequest_o, r1_waitrequest_o;
    logic [DW-1:0] r0_readdata_o, r1_readdata_o;
    logic          r0_readdatavalid_o, r1_readdatavalid_o;
    logic [AW-1:0] avm_address_o;
    logic          avm_read_o, avm_write_o;
    logic [DW-1:0] avm_writedata_o;
    logic          avm_waitrequest_i;
    logic [DW-1:0] avm_readdata_i;
    logic          avm_readdatavalid_i;
    logic [3:0]    pend_count_o;
    logic          err_rdv_o;

    logic          slv_rdv = 1'b0;
    logic          tb_rdv = 1'b0;
    assign avm_readdatavalid_i = slv_rdv | tb_rdv;

    avalon_ddr_arbiter_2to1 #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_PEND(MP)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .r0_address_i       (r0_address_i),
        .r0_read_i          (r0_read_i),
        .r0_write_i         (r0_write_i),
        .r0_writedata_i     (r0_writedata_i),
        .r0_waitrequest_o   (r0_waitrequest_o),
        .r0_readdata_o      (r0_readdata_o),
        .r0_readdatavalid_o (r0_readdatavalid_o),
        .r1_address_i       (r1_address_i),
        .r1_read_i          (r1_read_i),
        .r1_write_i         (r1_write_i),
        .r1_writedata_i     (r1_writedata_i),
        .r1_waitrequest_o   (r1_waitrequest_o),
        .r1_readdata_o      (r1_readdata_o),
        .r1_readdatavalid_o (r1_readdatavalid_o),
        .avm_address_o      (avm_address_o),
        .avm_read_o         (avm_read_o),
        .avm_write_o        (avm_write_o),
        .avm_writedata_o    (avm_writedata_o),
        .avm_waitrequest_i  (avm_waitrequest_i),
        .avm_readdata_i     (avm_readdata_i),
        .avm_readdatavalid_i(avm_readdatavalid_i),
        .pend_count_o       (pend_count_o),
        .err_rdv_o          (err_rdv_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard of expected read returns, in issue order.
    typedef struct {
        logic          id;
        logic [AW-1:0] addr;
    } exp_t;
    exp_t exp_q[$];

    // Slave model: returns each accepted read slv_lat cycles later, data = address replicated.
    int unsigned   cyc = 0;
    int unsigned   slv_lat = 5;
    bit            slv_en = 1'b1;
    int unsigned   slv_due[$];
    logic [AW-1:0] slv_addr[$];

    always @(posedge clk_i) begin
        if (rst_ni && avm_read_o && !avm_waitrequest_i) begin
            slv_due.push_back(cyc + slv_lat);
            slv_addr.push_back(avm_address_o);
        end
        cyc++;
        #1;
        slv_rdv = 1'b0;
        if (rst_ni && slv_en && slv_due.size() > 0 && slv_due[0] <= cyc) begin
            slv_rdv        = 1'b1;
            avm_readdata_i = {8{slv_addr[0]}};
            void'(slv_due.pop_front());
            void'(slv_addr.pop_front());
        end
    end

    // One clock: compare any routed read beat against the scoreboard at the falling edge,
    // then return 2 time units after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk_i);
        if (r0_readdatavalid_o || r1_readdatavalid_o) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rdv_route: got beat r0=%b r1=%b, expected no beat",
                         r0_readdatavalid_o, r1_readdatavalid_o);
            end else begin
                e = exp_q.pop_front();
                if ((r0_readdatavalid_o && r1_readdatavalid_o) || r1_readdatavalid_o !== e.id
                    || r0_readdata_o !== {8{e.addr}}) begin
                    n_err++;
                    $display("FAIL rdv_route: got r0=%b r1=%b data=%h, expected id=%0d addr=%h",
                             r0_readdatavalid_o, r1_readdatavalid_o, r0_readdata_o[31:0],
                             e.id, e.addr);
                end
            end
        end
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_reset();
        rst_ni            = 1'b0;
        r0_read_i         = 1'b0;
        r0_write_i        = 1'b0;
        r1_read_i         = 1'b0;
        r1_write_i        = 1'b0;
        r0_address_i      = '0;
        r1_address_i      = '0;
        r0_writedata_i    = '0;
        r1_writedata_i    = '0;
        avm_waitrequest_i = 1'b0;
        tb_rdv            = 1'b0;
        slv_en            = 1'b1;
        slv_lat           = 5;
        slv_due.delete();
        slv_addr.delete();
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++;
        if (avm_read_o !== 1'b0 || avm_write_o !== 1'b0 || r0_waitrequest_o !== 1'b1
            || r1_waitrequest_o !== 1'b1) begin
            n_err++;
            $display("FAIL idle: rd=%b wr=%b w0=%b w1=%b, expected 0 0 1 1",
                     avm_read_o, avm_write_o, r0_waitrequest_o, r1_waitrequest_o);
        end
        tick();
        rst_ni     = 1'b0;
        r0_read_i  = 1'b1;
        r1_write_i = 1'b1;
        tb_rdv     = 1'b1;
        #1;
        n_vec++;
        if (avm_read_o !== 1'b0 || avm_write_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_cmd: rd=%b wr=%b, expected 0 0", avm_read_o, avm_write_o);
        end
        n_vec++;
        if (r0_waitrequest_o !== 1'b1 || r1_waitrequest_o !== 1'b1) begin
            n_err++;
            $display("FAIL rst_wait: w0=%b w1=%b, expected 1 1",
                     r0_waitrequest_o, r1_waitrequest_o);
        end
        n_vec++;
        if (r0_readdatavalid_o !== 1'b0 || r1_readdatavalid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_rdv: v0=%b v1=%b, expected 0 0",
                     r0_readdatavalid_o, r1_readdatavalid_o);
        end
        @(posedge clk_i);
        #3;
        n_vec++;
        if (pend_count_o !== 4'd0 || err_rdv_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_state: pend=%0d err=%b, expected 0 0", pend_count_o, err_rdv_o);
        end
        tb_rdv = 1'b0;
    endtask

    task automatic test_write_single();
        logic [DW-1:0] wd;
        do_reset();
        wd             = {8{$urandom()}};
        r0_address_i   = 32'h100;
        r0_writedata_i = wd;
        r0_write_i     = 1'b1;
        #1;
        n_vec++;
        if (avm_write_o !== 1'b1 || avm_read_o !== 1'b0 || avm_address_o !== 32'h100
            || avm_writedata_o !== wd) begin
            n_err++;
            $display("FAIL wr_cmd: wr=%b rd=%b addr=%h, expected 1 0 100",
                     avm_write_o, avm_read_o, avm_address_o);
        end
        n_vec++;
        if (r0_waitrequest_o !== 1'b0 || r1_waitrequest_o !== 1'b1) begin
            n_err++;
            $display("FAIL wr_wait: w0=%b w1=%b, expected 0 1",
                     r0_waitrequest_o, r1_waitrequest_o);
        end
        tick();
        r0_write_i = 1'b0;
        #1;
        n_vec++;
        if (pend_count_o !== 4'd0 || avm_write_o !== 1'b0) begin
            n_err++;
            $display("FAIL wr_nopend: pend=%0d wr=%b, expected 0 0", pend_count_o, avm_write_o);
        end
    endtask

    task automatic test_rr_reads();
        logic          g;
        logic [AW-1:0] a;
        exp_t          e;
        do_reset();
        r0_read_i = 1'b1;
        r1_read_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g            = k[0];
            r0_address_i = 32'hA0 + k;
            r1_address_i = 32'hB0 + k;
            a            = g ? 32'hB0 + k : 32'hA0 + k;
            #1;
            n_vec++;
            if (avm_read_o !== 1'b1 || avm_address_o !== a || r0_waitrequest_o !== g
                || r1_waitrequest_o !== ~g) begin
                n_err++;
                $display("FAIL rr_grant%0d: rd=%b addr=%h w0=%b w1=%b, expected 1 %h %b %b",
                         k, avm_read_o, avm_address_o, r0_waitrequest_o, r1_waitrequest_o,
                         a, g, ~g);
            end
            e.id   = g;
            e.addr = a;
            exp_q.push_back(e);
            tick();
        end
        r0_read_i = 1'b0;
        r1_read_i = 1'b0;
        #1;
        n_vec++;
        if (pend_count_o !== 4'd4) begin
            n_err++;
            $display("FAIL rr_pend: pend=%0d, expected 4", pend_count_o);
        end
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
        n_vec++;
        if (exp_q.size() != 0 || pend_count_o !== 4'd0) begin
            n_err++;
            $display("FAIL rr_drain: left=%0d pend=%0d, expected 0 0", exp_q.size(), pend_count_o);
        end
    endtask

    task automatic test_lock_hold();
        do_reset();
        r0_address_i      = 32'h200;
        r1_address_i      = 32'h300;
        r1_writedata_i    = {8{$urandom()}};
        r1_write_i        = 1'b1;
        avm_waitrequest_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c >= 1) r0_write_i = 1'b1;
            #1;
            n_vec++;
            if (avm_write_o !== 1'b1 || avm_address_o !== 32'h300 || r0_waitrequest_o !== 1'b1
                || r1_waitrequest_o !== 1'b1) begin
                n_err++;
                $display("FAIL lock_hold%0d: wr=%b addr=%h w0=%b w1=%b, expected 1 300 1 1",
                         c, avm_write_o, avm_address_o, r0_waitrequest_o, r1_waitrequest_o);
            end
            tick();
        end
        avm_waitrequest_i = 1'b0;
        #1;
        n_vec++;
        if (avm_address_o !== 32'h300 || r1_waitrequest_o !== 1'b0
            || r0_waitrequest_o !== 1'b1) begin
            n_err++;
            $display("FAIL lock_accept: addr=%h w0=%b w1=%b, expected 300 1 0",
                     avm_address_o, r0_waitrequest_o, r1_waitrequest_o);
        end
        tick();
        r1_address_i = 32'h304;
        #1;
        n_vec++;
        if (avm_address_o !== 32'h200 || r0_waitrequest_o !== 1'b0
            || r1_waitrequest_o !== 1'b1) begin
            n_err++;
            $display("FAIL rr_after_lock: addr=%h w0=%b w1=%b, expected 200 0 1",
                     avm_address_o, r0_waitrequest_o, r1_waitrequest_o);
        end
        tick();
        r0_write_i = 1'b0;
        r1_write_i = 1'b0;
    endtask

    task automatic test_full();
        exp_t e;
        bit   found;
        do_reset();
        slv_en    = 1'b0;
        r0_read_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            r0_address_i = 32'h400 + k;
            #1;
            n_vec++;
            if (avm_read_o !== 1'b1 || r0_waitrequest_o !== 1'b0) begin
                n_err++;
                $display("FAIL fill%0d: rd=%b w0=%b, expected 1 0", k, avm_read_o,
                         r0_waitrequest_o);
            end
            e.id   = 1'b0;
            e.addr = 32'h400 + k;
            exp_q.push_back(e);
            tick();
        end
        r0_address_i = 32'h4F0;
        r1_address_i = 32'h500;
        r1_write_i   = 1'b1;
        #1;
        n_vec++;
        if (pend_count_o !== 4'd8) begin
            n_err++;
            $display("FAIL full_pend: pend=%0d, expected 8", pend_count_o);
        end
        n_vec++;
        if (avm_read_o !== 1'b0 || avm_write_o !== 1'b1 || avm_address_o !== 32'h500
            || r0_waitrequest_o !== 1'b1 || r1_waitrequest_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_wr: rd=%b wr=%b addr=%h w0=%b w1=%b, expected 0 1 500 1 0",
                     avm_read_o, avm_write_o, avm_address_o, r0_waitrequest_o, r1_waitrequest_o);
        end
        tick();
        r1_write_i = 1'b0;
        #1;
        n_vec++;
        if (avm_read_o !== 1'b0 || r0_waitrequest_o !== 1'b1 || pend_count_o !== 4'd8) begin
            n_err++;
            $display("FAIL full_stall: rd=%b w0=%b pend=%0d, expected 0 1 8",
                     avm_read_o, r0_waitrequest_o, pend_count_o);
        end
        slv_en = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            #1;
            if (avm_read_o === 1'b1) found = 1'b1;
        end
        n_vec++;
        if (!found || pend_count_o !== 4'd7 || avm_address_o !== 32'h4F0) begin
            n_err++;
            $display("FAIL full_resume: issued=%b pend=%0d addr=%h, expected 1 7 4f0",
                     found, pend_count_o, avm_address_o);
        end
        if (found) begin
            e.id   = 1'b0;
            e.addr = 32'h4F0;
            exp_q.push_back(e);
        end
        tick();
        r0_read_i = 1'b0;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
        n_vec++;
        if (exp_q.size() != 0 || pend_count_o !== 4'd0) begin
            n_err++;
            $display("FAIL full_drain: left=%0d pend=%0d, expected 0 0",
                     exp_q.size(), pend_count_o);
        end
    endtask

    task automatic test_err_rdv();
        do_reset();
        rst_ni = 1'b0;
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        tb_rdv = 1'b1;
        #1;
        n_vec++;
        if (err_rdv_o !== 1'b0) begin
            n_err++;
            $display("FAIL err_pre: err=%b, expected 0", err_rdv_o);
        end
        tick();
        tb_rdv = 1'b0;
        #1;
        n_vec++;
        if (err_rdv_o !== 1'b1 || pend_count_o !== 4'd0) begin
            n_err++;
            $display("FAIL err_set: err=%b pend=%0d, expected 1 0", err_rdv_o, pend_count_o);
        end
        repeat (3) tick();
        n_vec++;
        if (err_rdv_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: err=%b, expected 1", err_rdv_o);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        slv_en    = 1'b0;
        r0_read_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            r0_address_i = 32'h600 + k;
            tick();
        end
        #1;
        n_vec++;
        if (pend_count_o !== 4'd3) begin
            n_err++;
            $display("FAIL mid_pend: pend=%0d, expected 3", pend_count_o);
        end
        rst_ni     = 1'b0;
        r1_write_i = 1'b1;
        #1;
        n_vec++;
        if (pend_count_o !== 4'd0 || avm_read_o !== 1'b0 || avm_write_o !== 1'b0
            || r0_waitrequest_o !== 1'b1 || r1_waitrequest_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_rst: pend=%0d rd=%b wr=%b w0=%b w1=%b, expected 0 0 0 1 1",
                     pend_count_o, avm_read_o, avm_write_o, r0_waitrequest_o, r1_waitrequest_o);
        end
        slv_due.delete();
        slv_addr.delete();
        exp_q.delete();
        @(posedge clk_i);
        #2;
        r1_write_i   = 1'b0;
        r0_address_i = 32'h700;
        slv_en       = 1'b1;
        rst_ni       = 1'b1;
        #1;
        n_vec++;
        if (avm_read_o !== 1'b1 || avm_address_o !== 32'h700 || r0_waitrequest_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reissue: rd=%b addr=%h w0=%b, expected 1 700 0",
                     avm_read_o, avm_address_o, r0_waitrequest_o);
        end
        e.id   = 1'b0;
        e.addr = 32'h700;
        exp_q.push_back(e);
        tick();
        r0_read_i = 1'b0;
        #1;
        n_vec++;
        if (pend_count_o !== 4'd1) begin
            n_err++;
            $display("FAIL mid_push: pend=%0d, expected 1", pend_count_o);
        end
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
        n_vec++;
        if (exp_q.size() != 0 || pend_count_o !== 4'd0 || err_rdv_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_drain: left=%0d pend=%0d err=%b, expected 0 0 0",
                     exp_q.size(), pend_count_o, err_rdv_o);
        end
    endtask

    initial begin
        avm_readdata_i = '0;
        test_reset();
        test_write_single();
        test_rr_reads();
        test_lock_hold();
        test_full();
        test_err_rdv();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
